// File: rtl/physics_pkg.sv
// Shared definitions for the player motion pipeline: collision bit indices,
// direction encodings, playerState field layout and the update FSM states.
package physics_pkg;

   localparam int TOP_COL   = 3;
   localparam int RIGHT_COL = 2;
   localparam int BOT_COL   = 1;
   localparam int LEFT_COL  = 0;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   localparam int POS_W = 10;
   localparam int SPD_W = 5;

   localparam int X_MSB    = 31;
   localparam int X_LSB    = 22;
   localparam int Y_MSB    = 21;
   localparam int Y_LSB    = 12;
   localparam int XS_MSB   = 11;
   localparam int XS_LSB   = 7;
   localparam int YS_MSB   = 6;
   localparam int YS_LSB   = 2;
   localparam int XDIR_BIT = 1;
   localparam int YDIR_BIT = 0;

   typedef struct packed {
      logic [POS_W-1:0] x_pos;
      logic [POS_W-1:0] y_pos;
      logic [SPD_W-1:0] x_speed;
      logic [SPD_W-1:0] y_speed;
      logic             x_dir;
      logic             y_dir;
   } player_state_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_UPDATE  = 2'd2
   } phys_state_e;

   function automatic logic [31:0] pack_state(input player_state_t s);
      logic [31:0] w;
      w                 = '0;
      w[X_MSB:X_LSB]    = s.x_pos;
      w[Y_MSB:Y_LSB]    = s.y_pos;
      w[XS_MSB:XS_LSB]  = s.x_speed;
      w[YS_MSB:YS_LSB]  = s.y_speed;
      w[XDIR_BIT]       = s.x_dir;
      w[YDIR_BIT]       = s.y_dir;
      return w;
   endfunction

   function automatic player_state_t unpack_state(input logic [31:0] w);
      player_state_t s;
      s.x_pos   = w[X_MSB:X_LSB];
      s.y_pos   = w[Y_MSB:Y_LSB];
      s.x_speed = w[XS_MSB:XS_LSB];
      s.y_speed = w[YS_MSB:YS_LSB];
      s.x_dir   = w[XDIR_BIT];
      s.y_dir   = w[YDIR_BIT];
      return s;
   endfunction

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchroniser for an asynchronous tick line plus a rising-edge
// detector producing a one-clk tick pulse.
module tick_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic tick
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic sync2_dly_q, sync2_dly_d;

   always_comb begin
      sync1_d     = async_in;
      sync2_d     = sync1_q;
      sync2_dly_d = sync2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync2_dly_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         sync2_dly_q <= sync2_dly_d;
      end
   end

   assign tick = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/player_physics.sv
// Per-tick player motion integrator: captures collision/buttons one clk after
// the synchronised tick, then updates position, speeds and directions.
module player_physics
   import physics_pkg::*;
#(
   parameter int INIT_X      = 64,
   parameter int INIT_Y      = 415,
   parameter int PLAYER_SIZE = 32,
   parameter int RUN_SPEED   = 3,
   parameter int JUMP_SPEED  = 14,
   parameter int GRAVITY     = 1,
   parameter int MAX_FALL    = 12,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sim_clk,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   input  logic [3:0]  playerCol,
   output logic [31:0] playerState,
   output logic        grounded,
   output logic        tick_done
);

   localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - PLAYER_SIZE);
   localparam logic signed [10:0] Y_MIN = 11'(PLAYER_SIZE - 1);
   localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);

   logic tick;

   tick_sync u_tick_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (sim_clk),
      .tick     (tick)
   );

   phys_state_e   fsm_q, fsm_d;
   player_state_t st_q, st_d;
   logic [3:0]    cap_col_q, cap_col_d;
   logic          cap_left_q, cap_left_d;
   logic          cap_right_q, cap_right_d;
   logic          cap_jump_q, cap_jump_d;
   logic          grounded_q, grounded_d;
   logic          tick_done_q, tick_done_d;

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         ST_IDLE:    if (tick) fsm_d = ST_CAPTURE;
         ST_CAPTURE: fsm_d = ST_UPDATE;
         ST_UPDATE:  fsm_d = ST_IDLE;
         default:    fsm_d = ST_IDLE;
      endcase
   end

   logic signed [10:0] x_ext, x_spd, x_step, x_clamp;
   logic signed [10:0] y_ext, y_spd, y_step, y_clamp;
   logic               x_blocked, y_blocked;
   logic [5:0]         ys_inc;

   always_comb begin
      st_d        = st_q;
      grounded_d  = grounded_q;
      tick_done_d = 1'b0;
      cap_col_d   = cap_col_q;
      cap_left_d  = cap_left_q;
      cap_right_d = cap_right_q;
      cap_jump_d  = cap_jump_q;

      // Position step runs on the speeds the resolver just checked.
      x_ext  = signed'({1'b0, st_q.x_pos});
      x_spd  = signed'({6'b0, st_q.x_speed});
      x_step = (st_q.x_dir == DIR_RIGHT) ? (x_ext + x_spd) : (x_ext - x_spd);
      if (x_step < 11'sd0)
         x_clamp = 11'sd0;
      else if (x_step > X_MAX)
         x_clamp = X_MAX;
      else
         x_clamp = x_step;
      x_blocked = (st_q.x_speed != '0) &&
                  ((st_q.x_dir == DIR_RIGHT) ? cap_col_q[RIGHT_COL] : cap_col_q[LEFT_COL]);

      y_ext  = signed'({1'b0, st_q.y_pos});
      y_spd  = signed'({6'b0, st_q.y_speed});
      y_step = (st_q.y_dir == DIR_DOWN) ? (y_ext + y_spd) : (y_ext - y_spd);
      if (y_step < Y_MIN)
         y_clamp = Y_MIN;
      else if (y_step > Y_MAX)
         y_clamp = Y_MAX;
      else
         y_clamp = y_step;
      y_blocked = (st_q.y_dir == DIR_DOWN) ? cap_col_q[BOT_COL] : cap_col_q[TOP_COL];

      ys_inc = {1'b0, st_q.y_speed} + 6'(GRAVITY);

      if (fsm_q == ST_CAPTURE) begin
         cap_col_d   = playerCol;
         cap_left_d  = btn_left;
         cap_right_d = btn_right;
         cap_jump_d  = btn_jump;
      end

      if (fsm_q == ST_UPDATE) begin
         tick_done_d = 1'b1;

         if (!x_blocked) st_d.x_pos = x_clamp[POS_W-1:0];
         if (!y_blocked) st_d.y_pos = y_clamp[POS_W-1:0];

         if (cap_left_q && !cap_right_q) begin
            st_d.x_dir   = DIR_LEFT;
            st_d.x_speed = SPD_W'(RUN_SPEED);
         end else if (cap_right_q && !cap_left_q) begin
            st_d.x_dir   = DIR_RIGHT;
            st_d.x_speed = SPD_W'(RUN_SPEED);
         end else begin
            st_d.x_speed = '0;
         end

         if ((st_q.y_dir == DIR_DOWN) && cap_col_q[BOT_COL]) begin
            grounded_d = 1'b1;
            if (cap_jump_q) begin
               st_d.y_dir   = DIR_UP;
               st_d.y_speed = SPD_W'(JUMP_SPEED);
            end else begin
               // Small probe speed keeps the floor contact visible next tick.
               st_d.y_speed = SPD_W'(GRAVITY);
            end
         end else if ((st_q.y_dir == DIR_UP) && cap_col_q[TOP_COL]) begin
            grounded_d   = 1'b0;
            st_d.y_dir   = DIR_DOWN;
            st_d.y_speed = SPD_W'(GRAVITY);
         end else begin
            grounded_d = 1'b0;
            if (st_q.y_dir == DIR_UP) begin
               if (st_q.y_speed <= SPD_W'(GRAVITY)) begin
                  st_d.y_dir   = DIR_DOWN;
                  st_d.y_speed = '0;
               end else begin
                  st_d.y_speed = st_q.y_speed - SPD_W'(GRAVITY);
               end
            end else if (ys_inc > 6'(MAX_FALL)) begin
               st_d.y_speed = SPD_W'(MAX_FALL);
            end else begin
               st_d.y_speed = ys_inc[SPD_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q         <= ST_IDLE;
         st_q.x_pos    <= POS_W'(INIT_X);
         st_q.y_pos    <= POS_W'(INIT_Y);
         st_q.x_speed  <= '0;
         st_q.y_speed  <= '0;
         st_q.x_dir    <= DIR_RIGHT;
         st_q.y_dir    <= DIR_DOWN;
         cap_col_q     <= '0;
         cap_left_q    <= 1'b0;
         cap_right_q   <= 1'b0;
         cap_jump_q    <= 1'b0;
         grounded_q    <= 1'b0;
         tick_done_q   <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         st_q          <= st_d;
         cap_col_q     <= cap_col_d;
         cap_left_q    <= cap_left_d;
         cap_right_q   <= cap_right_d;
         cap_jump_q    <= cap_jump_d;
         grounded_q    <= grounded_d;
         tick_done_q   <= tick_done_d;
      end
   end

   assign playerState = pack_state(st_q);
   assign grounded    = grounded_q;
   assign tick_done   = tick_done_q;

endmodule

// File: tb/tb_player_physics.sv
// Directed scoreboard bench for player_physics: each tick pushes its expected
// playerState/grounded, a monitor pops and compares on every tick_done pulse.
module tb_player_physics;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sim_clk;
   logic        btn_left, btn_right, btn_jump;
   logic [3:0]  playerCol;
   logic [31:0] playerState;
   logic        grounded;
   logic        tick_done;

   player_physics dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sim_clk     (sim_clk),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_jump    (btn_jump),
      .playerCol   (playerCol),
      .playerState (playerState),
      .grounded    (grounded),
      .tick_done   (tick_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] word;
      logic        gnd;
      int          issue;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   pulses = 0;

   function automatic logic [31:0] mk(input int x, input int y, input int xs,
                                      input int ys, input int xd, input int yd);
      return {x[9:0], y[9:0], xs[4:0], ys[4:0], xd[0], yd[0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got x=%0d y=%0d xs=%0d ys=%0d xd=%0d yd=%0d (%h) want x=%0d y=%0d xs=%0d ys=%0d xd=%0d yd=%0d (%h)",
                  nm, act[31:22], act[21:12], act[11:7], act[6:2], act[1], act[0], act,
                  exp[31:22], exp[21:12], exp[11:7], exp[6:2], exp[1], exp[0], exp);
      end
   endtask

   // Monitor: every tick_done pulse must match the oldest outstanding tick.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && tick_done === 1'b1) begin
         exp_t e;
         pulses++;
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tick_done: got pulse at cycle %0d want none", cyc);
         end else begin
            e = sb_q.pop_front();
            $display("tick %s: state=%h grounded=%b latency=%0d", e.name, playerState, grounded, cyc - e.issue);
            chk({e.name, "_state"}, playerState, e.word);
            chk({e.name, "_grounded"}, {31'd0, grounded}, {31'd0, e.gnd});
            chk({e.name, "_latency"}, 32'(cyc - e.issue), 32'd5);
         end
      end
   end

   task automatic do_tick(input string nm, input logic l, input logic r, input logic j,
                          input logic [3:0] col, input int x, input int y, input int xs,
                          input int ys, input int xd, input int yd, input logic g);
      exp_t e;
      @(posedge clk);
      #1;
      btn_left  = l;
      btn_right = r;
      btn_jump  = j;
      playerCol = col;
      sim_clk   = 1'b1;
      e.word  = mk(x, y, xs, ys, xd, yd);
      e.gnd   = g;
      e.issue = cyc;
      e.name  = nm;
      sb_q.push_back(e);
      repeat (5) @(posedge clk);
      #1 sim_clk = 1'b0;
      repeat (5) @(posedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      while (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         total++;
         bad++;
         $display("FAIL missing_tick_done: tick %s got no pulse want one", e.name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ey;
      int eys;
      int pulses_before;
      rst_n     = 1'b0;
      sim_clk   = 1'b0;
      btn_left  = 1'b0;
      btn_right = 1'b0;
      btn_jump  = 1'b0;
      playerCol = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", playerState, mk(64, 415, 0, 0, 1, 0));
      chk("reset_flags", {30'd0, grounded, tick_done}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);

      do_tick("run_r1",    0, 1, 0, 4'b0000, 64, 415, 3,  1, 1, 0, 0);
      do_tick("run_r2",    0, 1, 0, 4'b0000, 67, 416, 3,  2, 1, 0, 0);
      do_tick("wall_r",    0, 1, 0, 4'b0100, 67, 418, 3,  3, 1, 0, 0);
      do_tick("coast",     0, 0, 0, 4'b0000, 70, 421, 0,  4, 1, 0, 0);
      do_tick("fall",      0, 0, 0, 4'b0000, 70, 425, 0,  5, 1, 0, 0);
      do_tick("land",      0, 0, 0, 4'b0010, 70, 425, 0,  1, 1, 0, 1);
      do_tick("jump",      0, 0, 1, 4'b0010, 70, 425, 0, 14, 1, 1, 1);
      do_tick("rise",      0, 0, 0, 4'b0000, 70, 411, 0, 13, 1, 1, 0);
      do_tick("rise_jump", 0, 0, 1, 4'b0010, 70, 398, 0, 12, 1, 1, 0);
      do_tick("ceiling",   0, 0, 0, 4'b1000, 70, 398, 0,  1, 1, 0, 0);
      do_tick("drop",      0, 0, 0, 4'b0000, 70, 399, 0,  2, 1, 0, 0);
      do_tick("reland",    0, 0, 0, 4'b0010, 70, 399, 0,  1, 1, 0, 1);

      // Run left along the floor; the right contact bit is behind the motion.
      do_tick("turn_l",    1, 0, 0, 4'b0110, 70, 399, 3,  1, 0, 0, 1);
      for (int k = 1; k <= 23; k++)
         do_tick("run_l",  1, 0, 0, 4'b0110, 70 - 3 * k, 399, 3, 1, 0, 0, 1);
      do_tick("clamp_l",   1, 0, 0, 4'b0110, 0, 399, 3, 1, 0, 0, 1);
      do_tick("wall_l",    1, 0, 0, 4'b0011, 0, 399, 3, 1, 0, 0, 1);
      do_tick("both_btn",  1, 1, 0, 4'b0010, 0, 399, 0, 1, 0, 0, 1);

      do_tick("jump2",     0, 0, 1, 4'b0010, 0, 399, 0, 14, 0, 1, 1);
      ey = 399;
      for (int v = 14; v >= 2; v--) begin
         ey = ey - v;
         do_tick("ascend", 0, 0, 1, 4'b0000, 0, ey, 0, v - 1, 0, 1, 0);
      end
      do_tick("apex",      0, 0, 0, 4'b0000, 0, 294, 0, 0, 0, 0, 0);

      ey  = 294;
      eys = 0;
      for (int i = 0; i < 22; i++) begin
         ey  = (ey + eys > 479) ? 479 : ey + eys;
         eys = (eys + 1 > 12) ? 12 : eys + 1;
         do_tick("freefall", 0, 0, 0, 4'b0000, 0, ey, 0, eys, 0, 0, 0);
      end
      drain();

      // Reset while the FSM sits in UPDATE: nothing from that tick may land.
      pulses_before = pulses;
      @(posedge clk);
      #1;
      btn_right = 1'b1;
      sim_clk   = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("midrst_state", playerState, mk(64, 415, 0, 0, 1, 0));
      chk("midrst_flags", {30'd0, grounded, tick_done}, 32'd0);
      sim_clk = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("postrst_state", playerState, mk(64, 415, 0, 0, 1, 0));
      chk("postrst_pulses", 32'(pulses - pulses_before), 32'd0);

      do_tick("after_rst", 0, 0, 0, 4'b0000, 64, 415, 0, 1, 1, 0, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/player_physics.md
Name: player_physics

Overview:
Per-tick player motion integrator that sits directly downstream of collision_resolver. It consumes the 4-bit player collision vector for the state just checked, together with the button inputs, and produces the updated packed 32-bit playerState word that the resolver samples on its next pass. All updates occur once per sim_clk tick and are sequenced by a small FSM.

Parameters:
INIT_X, 64, spawn x (left edge, pixels)
INIT_Y, 415, spawn y (bottom edge, pixels)
PLAYER_SIZE, 32, sprite width/height
RUN_SPEED, 3, horizontal speed while a direction button is held
JUMP_SPEED, 14, initial upward speed
GRAVITY, 1, vertical speed change per tick
MAX_FALL, 12, downward speed cap (must be ≤31)
SCREEN_W, 640, playfield width
SCREEN_H, 480, playfield height

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
sim_clk  in  1  simulation tick, asynchronous to clk
btn_left  in  1  left held (already debounced/synchronised)
btn_right  in  1  right held
btn_jump  in  1  jump held
playerCol  in  4  {top, right, bot, left} from collision_resolver
playerState  out  32  {xPos[31:22], yPos[21:12], xSpeed[11:7], ySpeed[6:2], xDir[1], yDir[0]}
grounded  out  1  bottom contact on the last tick
tick_done  out  1  one-clk pulse when playerState has been updated

Behaviour:
- Reset (asynchronous, any time, including mid-update): xPos=INIT_X, yPos=INIT_Y, xSpeed=0, ySpeed=0, xDir=1 (right), yDir=0 (down), grounded=0, tick_done=0, sync flops=0, FSM=IDLE. No partial update survives.
- Tick detect: two flops synchronise sim_clk (s, ss), plus a third flop (ss_d). tick = ss & ~ss_d.
- FSM: IDLE -> (tick) CAPTURE -> UPDATE -> IDLE.
  - CAPTURE registers playerCol and the buttons, so the resolver's latch from the same sim_clk edge has settled.
  - UPDATE writes all fields and pulses tick_done for 1 cycle.
  - Latency: playerState changes 3 clk after the ss rising edge.
  - A tick arriving outside IDLE is dropped, which requires a sim_clk period of at least 4 clk.
- Encodings: xDir left=0/right=1; yDir down=0/up=1.
- Collision bits: playerCol[0] left, [1] bot, [2] right, [3] top.
- Position step (uses the pre-update speeds, which are the ones the resolver checked):
  - x: if xSpeed≠0 and the collision bit for xDir is set, x is held. Otherwise x±xSpeed, computed in 11-bit signed arithmetic and clamped to [0, SCREEN_W-PLAYER_SIZE].
  - y: if yDir=down and col[1] is set, or yDir=up and col[3] is set, y is held. Otherwise down adds ySpeed and up subtracts it, clamped to [PLAYER_SIZE-1, SCREEN_H-1].
- Horizontal speed (from captured buttons):
  - left only: xDir=0, xSpeed=RUN_SPEED.
  - right only: xDir=1, xSpeed=RUN_SPEED.
  - neither or both: xSpeed=0, xDir held.
- Vertical speed (priority order):
  1. yDir=down & col[1]: grounded=1. If jump is held, yDir=up and ySpeed=JUMP_SPEED; otherwise ySpeed=GRAVITY (a probe speed so ground contact is re-detected each tick).
  2. yDir=up & col[3]: grounded=0, yDir=down, ySpeed=GRAVITY.
  3. Otherwise grounded=0:
     - up: if ySpeed≤GRAVITY, yDir=down and ySpeed=0; else ySpeed-=GRAVITY.
     - down: ySpeed=min(ySpeed+GRAVITY, MAX_FALL).
- Jump is only possible on a tick that reports bottom contact; holding jump at the apex has no effect.
- Collision bits opposite to the direction of motion are ignored.

Decomposition:
- Shared package (physics_pkg):
  - collision bit indices TOP_COL=3, RIGHT_COL=2, BOT_COL=1, LEFT_COL=0
  - direction encodings
  - playerState field bit-ranges, plus pack/unpack functions shared with collision_resolver
  - FSM state constants
- One sub-module: tick_sync (2-flop synchroniser plus rising-edge detector, async active-low reset). It is reusable by collision_resolver.

Test Plan:
- Reset: assert rst_n=0 mid-run -> playerState immediately reads x=64, y=415, xSpeed=0, ySpeed=0, xDir=1, yDir=0; grounded=0.
- Run right: hold btn_right, col=0000, tick -> xSpeed=3, x=64. Second tick -> x=67. Third tick with col=0100 -> x stays 67.
- Landing: down at ySpeed=5, y=400, col=0010, tick -> y=400, ySpeed=1, grounded=1, tick_done pulses exactly once, 3 clk after the sync edge.
- Jump: grounded with btn_jump held and col=0010 -> yDir=1, ySpeed=14. Next tick with col=0000 -> y reduced by 14, ySpeed=13, grounded=0.
- Ceiling and apex:
  - up at ySpeed=6, col=1000 -> y held, yDir=0, ySpeed=1.
  - separately, up at ySpeed=1, col=0000 -> y-=1, yDir=0, ySpeed=0.
- Edges:
  - x=1, left at speed 3, col=0000 -> x=0.
  - falling at ySpeed=12 (MAX_FALL) -> stays 12.
  - rst_n pulsed between the tick edge and UPDATE -> no update, reset values, tick_done not pulsed.
